avalon_display_arbiter: RTL and testbench
=========================================

AVALON_DISPLAY_ARBITER -- requirements
Module: avalon_display_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, slave word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum slave-stall cycles per transfer, 1..255.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports m0_address/m1_address  in  ADDR_W  master word address.
REQ-007 SHALL have ports m0_read, m0_write, m1_read, m1_write  in  1  master command strobes.
REQ-008 SHALL have ports m0_writedata/m1_writedata  in  DATA_W  master write data.
REQ-009 SHALL have ports m0_readdata/m1_readdata  out  DATA_W  read data returned to master.
REQ-010 SHALL have ports m0_waitrequest/m1_waitrequest  out  1  per-master stall.
REQ-011 SHALL have ports s_address (ADDR_W), s_read, s_write (1), s_writedata (DATA_W)  out  shared-slave command.
REQ-012 SHALL have ports s_readdata (DATA_W), s_waitrequest (1)  in  shared-slave response.
REQ-013 SHALL have port timeout_err  out  1  sticky flag, slave stall exceeded TIMEOUT.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-015 Request for master n = mn_read OR mn_write.
REQ-016 In IDLE: req0 only -> GRANT0; req1 only -> GRANT1; both -> the master not equal to last_grant; none -> IDLE; transition on next clk edge (1-cycle arbitration latency).
REQ-017 In IDLE: s_read=s_write=0, both mn_waitrequest=1.
REQ-018 In GRANTn: s_address/s_read/s_write/s_writedata SHALL combinationally follow master n; other master's waitrequest=1.
REQ-019 In GRANTn: mn_waitrequest = s_waitrequest; mn_readdata = s_readdata (valid same cycle waitrequest low).
REQ-020 Non-granted master's readdata SHALL be 0.
REQ-021 Transfer completes on cycle in GRANTn with req_n=1 and s_waitrequest=0 -> next state IDLE, last_grant<=n, stall counter<=0.
REQ-022 Stall counter increments each GRANTn cycle with s_waitrequest=1; saturating 8-bit.
REQ-023 When stall counter == TIMEOUT and s_waitrequest=1: drive mn_waitrequest=0, mn_readdata=32'hDEADBEEF (low DATA_W bits), s_read=s_write=0 that cycle, set timeout_err, -> IDLE, last_grant<=n.
REQ-024 If req_n drops while in GRANTn (protocol violation): -> IDLE next cycle, no transfer counted, last_grant unchanged.
REQ-025 Both masters requesting continuously SHALL alternate grants strictly (0,1,0,1...).
REQ-026 m0_read and m0_write simultaneously SHALL be forwarded unchanged; arbiter does not filter.
REQ-027 timeout_err SHALL remain 1 until reset.

Reset
REQ-028 reset_n=0 SHALL immediately force state=IDLE, last_grant=1 (m0 wins first tie), stall counter=0, timeout_err=0.
REQ-029 During reset: s_read=s_write=0, m0_waitrequest=m1_waitrequest=1, readdata outputs 0.
REQ-030 Reset asserted mid-transfer SHALL abandon it with no completion signalled; after release, arbitration restarts from IDLE.
REQ-031 Reset release SHALL be safe when synchronous to clk; no internal synchronizer required.

Verification
REQ-032 Reset release, m0 write addr 3 data 0x12345678, slave waitrequest=0 -> GRANT0 at cycle 1, s_write=1 s_writedata=0x12345678 cycle 1, m0_waitrequest=0 cycle 1, IDLE cycle 2.
REQ-033 m0 and m1 read together from reset, slave readdata 0xA5 -> m0 served first, m1 served next grant; m1_readdata=0xA5 on its completion cycle, m0_waitrequest=1 throughout m1 grant.
REQ-034 Both masters hold requests for 6 transfers -> grant sequence 0,1,0,1,0,1; no master starved.
REQ-035 TIMEOUT=4, slave waitrequest stuck 1 on m1 read -> after 4 stall cycles m1_waitrequest=0, m1_readdata=0xDEADBEEF, timeout_err=1 and stays 1; next m0 transfer completes normally.
REQ-036 reset_n pulsed low during GRANT1 with slave stalling -> outputs reach reset values same cycle, timeout_err=0, first post-reset tie granted to m0.
REQ-037 m1 drops read while granted -> IDLE next cycle, last_grant unchanged, pending m0 then granted.

Source files
------------

// File: rtl/avalon_display_arbiter_if.sv
// Avalon-MM style bus bundle shared by the arbiter's two master-facing
// ports and its single slave-facing port.
interface avalon_display_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  // The side that issues commands and receives responses.
  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  // The side that accepts commands and returns responses.
  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_display_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter. Ties are resolved in favour of the
// master that was not served last, so continuous requesters alternate.
// A per-transfer stall counter aborts a transfer whose slave never releases
// waitrequest, returning a marker word and raising a sticky error flag.
module avalon_display_arbiter #(
  parameter int          ADDR_W  = 4,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  avalon_display_arbiter_if.slave  m0,
  avalon_display_arbiter_if.slave  m1,
  avalon_display_arbiter_if.master s,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        stall_q, stall_d;
  logic              set_timeout;

  logic              req0, req1;
  logic              g1;
  logic              g_req;
  logic              resp_wait;
  logic [DATA_W-1:0] resp_data;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // State, fairness history, stall counter and sticky error register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      stall_q      <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Arbitration decision, slave command mux and per-master response routing.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    stall_d       = stall_q;
    set_timeout   = 1'b0;
    g1            = 1'b0;
    g_req         = 1'b0;
    resp_wait     = 1'b1;
    resp_data     = '0;
    s.address     = '0;
    s.read        = 1'b0;
    s.write       = 1'b0;
    s.writedata   = '0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    m0.readdata   = '0;
    m1.readdata   = '0;

    case (state_q)
      IDLE: begin
        stall_d = 8'd0;
        if (req0 && req1) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        g1          = (state_q == GRANT1);
        g_req       = g1 ? req1 : req0;
        s.address   = g1 ? m1.address   : m0.address;
        s.read      = g1 ? m1.read      : m0.read;
        s.write     = g1 ? m1.write     : m0.write;
        s.writedata = g1 ? m1.writedata : m0.writedata;
        resp_wait   = s.waitrequest;
        resp_data   = s.readdata;

        if (!g_req) begin
          // Master withdrew mid-grant: drop back without crediting a transfer.
          state_d = IDLE;
          stall_d = 8'd0;
        end else if (!s.waitrequest) begin
          state_d      = IDLE;
          last_grant_d = g1;
          stall_d      = 8'd0;
        end else if (stall_q == 8'(TIMEOUT)) begin
          resp_wait    = 1'b0;
          resp_data    = DATA_W'(TIMEOUT_WORD);
          s.read       = 1'b0;
          s.write      = 1'b0;
          set_timeout  = 1'b1;
          state_d      = IDLE;
          last_grant_d = g1;
          stall_d      = 8'd0;
        end else if (stall_q != 8'hFF) begin
          stall_d = stall_q + 8'd1;
        end

        if (g1) begin
          m1.waitrequest = resp_wait;
          m1.readdata    = resp_data;
        end else begin
          m0.waitrequest = resp_wait;
          m0.readdata    = resp_data;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs take their quiet values for as long as reset is held, without
    // waiting for the state register to be observed.
    if (!reset_n) begin
      s.read         = 1'b0;
      s.write        = 1'b0;
      m0.waitrequest = 1'b1;
      m1.waitrequest = 1'b1;
      m0.readdata    = '0;
      m1.readdata    = '0;
      set_timeout    = 1'b0;
    end
  end

endmodule

// File: tb/tb_avalon_display_arbiter.sv
// Self-checking bench for avalon_display_arbiter: directed transfers push
// their expected completion into a scoreboard queue, and a negedge monitor
// pops and compares whenever a requesting master sees waitrequest low.
module tb_avalon_display_arbiter;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic timeout_err;

  always #5 clk = ~clk;

  avalon_display_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  avalon_display_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  avalon_display_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  avalon_display_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .s          (s_bus),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int                mst;
    logic              rd;
    logic              to;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sbq[$];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int cyc0, cyc1, cyc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checkCount++;
    if (act === expv) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int mst, input logic rd, input logic wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    if (mst == 0) begin
      m0_bus.read      = rd;
      m0_bus.write     = wr;
      m0_bus.address   = addr;
      m0_bus.writedata = data;
    end else begin
      m1_bus.read      = rd;
      m1_bus.write     = wr;
      m1_bus.address   = addr;
      m1_bus.writedata = data;
    end
  endtask

  task automatic pushExp(input int mst, input logic rd, input logic to,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    exp_t e;
    e.mst  = mst;
    e.rd   = rd;
    e.to   = to;
    e.addr = addr;
    e.data = data;
    sbq.push_back(e);
  endtask

  // Hold a request until the master sees waitrequest low, then release it.
  task automatic doXfer(input int mst, input logic rd, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, output int cycles);
    logic done;
    done   = 1'b0;
    cycles = 0;
    applyStimulus(mst, rd, !rd, addr, data);
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (mst == 0 ? !m0_bus.waitrequest : !m1_bus.waitrequest) done = 1'b1;
    end
    checkOutput("xfer_done", 64'(done), 64'(1));
    @(posedge clk);
    #1;
    applyStimulus(mst, 1'b0, 1'b0, addr, data);
  endtask

  task automatic checkXfer(input int mst);
    exp_t              e;
    logic [DATA_W-1:0] rdv;
    logic [DATA_W-1:0] dv;
    logic [1:0]        expCmd;
    if (sbq.size() == 0) begin
      checkOutput("sb_pending", 64'(sbq.size()), 64'(1));
    end else begin
      e      = sbq.pop_front();
      rdv    = (mst == 1) ? m1_bus.readdata : m0_bus.readdata;
      dv     = (e.rd || e.to) ? rdv : s_bus.writedata;
      expCmd = e.to ? 2'b00 : (e.rd ? 2'b10 : 2'b01);
      checkOutput("sb_xfer",
                  64'({s_bus.read, s_bus.write, (mst == 1), s_bus.address, dv}),
                  64'({expCmd, (e.mst == 1), e.addr, e.data}));
    end
  endtask

  // Completion monitor: a requesting master with waitrequest low has finished.
  always @(negedge clk) begin
    if (reset_n) begin
      if ((m0_bus.read || m0_bus.write) && !m0_bus.waitrequest) checkXfer(0);
      if ((m1_bus.read || m1_bus.write) && !m1_bus.waitrequest) checkXfer(1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    s_bus.waitrequest = 1'b0;
    s_bus.readdata    = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wait",  64'({m0_bus.waitrequest, m1_bus.waitrequest}), 64'(2'b11));
    checkOutput("rst_cmd",   64'({s_bus.read, s_bus.write}), 64'(2'b00));
    checkOutput("rst_rdata", 64'({m0_bus.readdata, m1_bus.readdata}), 64'(0));
    checkOutput("rst_terr",  64'(timeout_err), 64'(0));

    // Single m0 write straight after reset release, cycle by cycle.
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(0, 1'b0, 1'b1, 4'd3, 32'h12345678);
    pushExp(0, 1'b0, 1'b0, 4'd3, 32'h12345678);
    @(negedge clk);
    checkOutput("a_c0_idle", 64'({m0_bus.waitrequest, s_bus.write}), 64'(2'b10));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("a_c1_write", 64'({s_bus.write, s_bus.writedata}), 64'({1'b1, 32'h12345678}));
    checkOutput("a_c1_wait",  64'(m0_bus.waitrequest), 64'(0));
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 4'd3, 32'h12345678);
    @(negedge clk);
    checkOutput("a_c2_idle", 64'({m0_bus.waitrequest, s_bus.write}), 64'(2'b10));

    // Tie from reset: m0 first, then m1.
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s_bus.readdata = 32'h000000A5;
    pushExp(0, 1'b1, 1'b0, 4'd1, 32'h000000A5);
    pushExp(1, 1'b1, 1'b0, 4'd2, 32'h000000A5);
    fork
      doXfer(0, 1'b1, 4'd1, '0, cyc0);
      doXfer(1, 1'b1, 4'd2, '0, cyc1);
    join

    // Continuous requests alternate 0,1,0,1,0,1.
    for (int i = 0; i < 3; i++) begin
      pushExp(0, 1'b0, 1'b0, 4'(i), 32'h100 + 32'(i));
      pushExp(1, 1'b0, 1'b0, 4'(i + 8), 32'h200 + 32'(i));
    end
    fork
      begin
        for (int i = 0; i < 3; i++) doXfer(0, 1'b0, 4'(i), 32'h100 + 32'(i), cyc0);
      end
      begin
        for (int j = 0; j < 3; j++) doXfer(1, 1'b0, 4'(j + 8), 32'h200 + 32'(j), cyc1);
      end
    join

    // Stuck slave on an m1 read: 1 idle cycle + 4 stalls + timeout cycle.
    s_bus.waitrequest = 1'b1;
    pushExp(1, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF);
    doXfer(1, 1'b1, 4'd5, '0, cyc);
    checkOutput("d_timeout_latency", 64'(cyc), 64'(6));
    checkOutput("d_terr_set", 64'(timeout_err), 64'(1));
    s_bus.waitrequest = 1'b0;
    pushExp(0, 1'b0, 1'b0, 4'd6, 32'hCAFE0001);
    doXfer(0, 1'b0, 4'd6, 32'hCAFE0001, cyc);
    checkOutput("d_terr_sticky", 64'(timeout_err), 64'(1));

    // Reset during a stalled m1 grant.
    s_bus.waitrequest = 1'b1;
    s_bus.readdata    = 32'h00000077;
    applyStimulus(1, 1'b1, 1'b0, 4'd7, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("e_grant1", 64'({m1_bus.waitrequest, s_bus.read}), 64'(2'b11));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("e_rst_cmd",   64'({s_bus.read, s_bus.write}), 64'(2'b00));
    checkOutput("e_rst_wait",  64'({m0_bus.waitrequest, m1_bus.waitrequest}), 64'(2'b11));
    checkOutput("e_rst_rdata", 64'(m1_bus.readdata), 64'(0));
    checkOutput("e_rst_terr",  64'(timeout_err), 64'(0));
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s_bus.waitrequest = 1'b0;
    s_bus.readdata    = 32'h0000005A;
    pushExp(0, 1'b1, 1'b0, 4'd8, 32'h0000005A);
    pushExp(1, 1'b1, 1'b0, 4'd9, 32'h0000005A);
    fork
      doXfer(0, 1'b1, 4'd8, '0, cyc0);
      doXfer(1, 1'b1, 4'd9, '0, cyc1);
    join

    // m1 withdraws while granted; the pending m0 is served next.
    s_bus.waitrequest = 1'b1;
    s_bus.readdata    = 32'h0000003C;
    applyStimulus(1, 1'b1, 1'b0, 4'd10, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("f_grant1", 64'({m1_bus.waitrequest, s_bus.read}), 64'(2'b11));
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    s_bus.waitrequest = 1'b0;
    pushExp(0, 1'b1, 1'b0, 4'd10, 32'h0000003C);
    doXfer(0, 1'b1, 4'd10, '0, cyc);

    // Withdrawal must not update fairness: after m0 was served, m1 wins the tie.
    s_bus.waitrequest = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 4'd11, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("f2_grant1", 64'({m0_bus.waitrequest, s_bus.read}), 64'(2'b11));
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    s_bus.waitrequest = 1'b0;
    pushExp(1, 1'b1, 1'b0, 4'd11, 32'h0000003C);
    pushExp(0, 1'b1, 1'b0, 4'd12, 32'h0000003C);
    fork
      doXfer(1, 1'b1, 4'd11, '0, cyc1);
      doXfer(0, 1'b1, 4'd12, '0, cyc0);
    join

    @(negedge clk);
    checkOutput("sb_drain", 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
